l2_burst_adaptor: RTL and testbench

//  Bridges the L2 cache to physical memory. Each 256-bit line request (fill or writeback) is turned into a 4-beat, 64-bit burst.

---
 rtl/l2_types.sv | 31 +++
 rtl/l2_burst_adaptor_beat_counter.sv | 27 ++
 rtl/l2_burst_adaptor.sv | 134 +++++++++++++
 tb/tb_l2_burst_adaptor.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/l2_types.sv
// Shared types and constants for the L2 burst adaptor.
// Optional macro L2_ADAPTOR_WB_BUF_EN adds the WR_ACK state for posted writes.
package l2_types;

    localparam int L2_NUM_BEATS = 4;
    localparam int L2_BEAT_W    = 64;
    localparam int L2_LINE_W    = 256;
    localparam int L2_OFFSET_W  = 5;

    // A line viewed as its memory beats; beat 0 is the low 64 bits.
    typedef logic [L2_NUM_BEATS-1:0][L2_BEAT_W-1:0] l2_line_t;

    typedef enum logic [2:0] {
        IDLE,
        RD_BURST,
        RD_DONE,
        WR_BURST,
`ifdef L2_ADAPTOR_WB_BUF_EN
        WR_DONE,
        WR_ACK
`else
        WR_DONE
`endif
    } l2_adaptor_state_t;

    // Memory is addressed per line, so the offset bits are always cleared.
    function automatic logic [31:0] line_align(input logic [31:0] addr);
        return addr & ~((32'd1 << L2_OFFSET_W) - 32'd1);
    endfunction

endpackage

// File: rtl/l2_burst_adaptor_beat_counter.sv
// Beat counter for one 4-beat burst: clears while idle, counts accepted beats.
module l2_beat_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       resp_i,
    output logic [1:0] cnt,
    output logic       last_beat
);

    // Count beats; the 2-bit width makes the final beat wrap back to 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= 2'd0;
        end else if (clear) begin
            cnt <= 2'd0;
        end else if (resp_i) begin
            // NOTE: state registers use non-blocking assignments so every flop
            // samples values from before the edge, independent of block order.
            cnt <= cnt + 2'd1;
        end
    end

    // Flag the beat that completes the burst.
    assign last_beat = resp_i && (cnt == 2'd3);

endmodule

// File: rtl/l2_burst_adaptor.sv
// L2 line <-> 4-beat memory burst adaptor (fill and writeback).
// Optional macro L2_ADAPTOR_WB_BUF_EN: posted writeback, completion is
// acknowledged to L2 before the burst drains to memory.
module l2_burst_adaptor
    import l2_types::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          address_i,
    input  logic                 read_i,
    input  logic                 write_i,
    input  logic [L2_LINE_W-1:0] line_i,
    output logic [L2_LINE_W-1:0] line_o,
    output logic                 resp_o,
    output logic [31:0]          address_o,
    output logic                 read_o,
    output logic                 write_o,
    output logic [L2_BEAT_W-1:0] burst_o,
    input  logic [L2_BEAT_W-1:0] burst_i,
    input  logic                 resp_i
);

    l2_adaptor_state_t state_q, state_d;
    logic [31:0]       addr_q;
    l2_line_t          wr_line_q;
    l2_line_t          rd_buf_q;
    l2_line_t          line_q;
    logic [1:0]        cnt;
    logic              last_beat;
    logic              beat_inc;

    // Beats only count while a burst is on the bus; resp_i is ignored otherwise.
    assign beat_inc = resp_i && ((state_q == RD_BURST) || (state_q == WR_BURST));

    l2_beat_counter u_beat_counter (
        .clk       (clk),
        .rst       (rst),
        .clear     (state_q == IDLE),
        .resp_i    (beat_inc),
        .cnt       (cnt),
        .last_beat (last_beat)
    );

    // State register; reset abandons any burst in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and bus outputs; outputs decode state so reset drops them at once.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned,
        // which would otherwise infer a latch.
        state_d = state_q;
        read_o  = 1'b0;
        write_o = 1'b0;
        resp_o  = 1'b0;
        burst_o = '0;
        case (state_q)
            IDLE: begin
                if (write_i) begin
`ifdef L2_ADAPTOR_WB_BUF_EN
                    state_d = WR_ACK;
`else
                    state_d = WR_BURST;
`endif
                end else if (read_i) begin
                    state_d = RD_BURST;
                end
            end
            RD_BURST: begin
                read_o = 1'b1;
                if (last_beat) state_d = RD_DONE;
            end
            RD_DONE: begin
                resp_o  = 1'b1;
                state_d = IDLE;
            end
`ifdef L2_ADAPTOR_WB_BUF_EN
            WR_ACK: begin
                resp_o  = 1'b1;
                state_d = WR_BURST;
            end
`endif
            WR_BURST: begin
                write_o = 1'b1;
                burst_o = wr_line_q[cnt];
`ifdef L2_ADAPTOR_WB_BUF_EN
                if (last_beat) state_d = IDLE;
`else
                if (last_beat) state_d = WR_DONE;
`endif
            end
            WR_DONE: begin
                resp_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Request latches and fill-line assembly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the data registers are reset because line_o and address_o
            // must read zero during reset and a partial fill must be discarded.
            addr_q    <= '0;
            wr_line_q <= '0;
            rd_buf_q  <= '0;
            line_q    <= '0;
        end else begin
            if (state_q == IDLE) begin
                if (write_i) begin
                    addr_q    <= line_align(address_i);
                    wr_line_q <= line_i;
                end else if (read_i) begin
                    addr_q <= line_align(address_i);
                end
            end
            if ((state_q == RD_BURST) && beat_inc) begin
                rd_buf_q[cnt] <= burst_i;
                // line_o only changes once a complete line is available.
                if (last_beat) line_q <= {burst_i, rd_buf_q[2], rd_buf_q[1], rd_buf_q[0]};
            end
        end
    end

    assign address_o = addr_q;
    assign line_o    = line_q;

endmodule

// File: tb/tb_l2_burst_adaptor.sv
// Self-checking bench for l2_burst_adaptor; honours L2_ADAPTOR_WB_BUF_EN if defined.
module tb_l2_burst_adaptor;

    typedef logic [255:0] line_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] address_i;
    logic        read_i;
    logic        write_i;
    line_t       line_i;
    line_t       line_o;
    logic        resp_o;
    logic [31:0] address_o;
    logic        read_o;
    logic        write_o;
    logic [63:0] burst_o;
    logic [63:0] burst_i;
    logic        resp_i;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference memory: whole lines keyed by line number.
    line_t mem [logic [26:0]];

    l2_burst_adaptor dut (
        .clk       (clk),
        .rst       (rst),
        .address_i (address_i),
        .read_i    (read_i),
        .write_i   (write_i),
        .line_i    (line_i),
        .line_o    (line_o),
        .resp_o    (resp_o),
        .address_o (address_o),
        .read_o    (read_o),
        .write_o   (write_o),
        .burst_o   (burst_o),
        .burst_i   (burst_i),
        .resp_i    (resp_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] observed, input logic [255:0] expected);
        n_assert++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic line_t rand_line();
        line_t l;
        for (int i = 0; i < 8; i++) l[32*i +: 32] = $urandom;
        return l;
    endfunction

    function automatic line_t mem_read(input logic [26:0] la);
        if (!mem.exists(la)) mem[la] = rand_line();
        return mem[la];
    endfunction

    // L2 issues a fill; memory returns the model's line, optionally with gaps.
    task automatic do_fill(input logic [31:0] addr, input bit gaps);
        logic [26:0] la;
        line_t       exp;
        la  = addr[31:5];
        exp = mem_read(la);
        read_i    = 1'b1;
        address_i = addr;
        step();
        check("fill_read_o", read_o, 1'b1);
        check("fill_address_o", address_o, {la, 5'b0});
        for (int b = 0; b < 4; b++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    resp_i = 1'b0;
                    step();
                    check("fill_gap_read_o", read_o, 1'b1);
                    check("fill_gap_resp_o", resp_o, 1'b0);
                end
            end
            resp_i  = 1'b1;
            burst_i = exp[64*b +: 64];
            step();
            resp_i  = 1'b0;
            burst_i = '0;
            if (b < 3) check("fill_mid_read_o", read_o, 1'b1);
        end
        check("fill_read_o_drop", read_o, 1'b0);
        check("fill_resp_o", resp_o, 1'b1);
        check("fill_line_o", line_o, exp);
        read_i = 1'b0;
        step();
        check("fill_resp_o_pulse", resp_o, 1'b0);
        check("fill_line_o_hold", line_o, exp);
    endtask

    // L2 issues a writeback; optionally read_i is raised alongside it.
    task automatic do_write(input logic [31:0] addr, input line_t data, input bit gaps, input bit read_too);
        logic [26:0] la;
        la        = addr[31:5];
        write_i   = 1'b1;
        read_i    = read_too;
        line_i    = data;
        address_i = addr;
        step();
`ifdef L2_ADAPTOR_WB_BUF_EN
        check("wack_resp_o", resp_o, 1'b1);
        check("wack_write_o", write_o, 1'b0);
        write_i = 1'b0;
        step();
        check("wack_resp_o_pulse", resp_o, 1'b0);
`endif
        check("wr_write_o", write_o, 1'b1);
        check("wr_address_o", address_o, {la, 5'b0});
        for (int b = 0; b < 4; b++) begin
            check("wr_burst_o", burst_o, {192'd0, data[64*b +: 64]});
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    resp_i = 1'b0;
                    step();
                    check("wr_gap_write_o", write_o, 1'b1);
                    check("wr_gap_burst_o", burst_o, {192'd0, data[64*b +: 64]});
                end
            end
            check("wr_read_o_held_off", read_o, 1'b0);
            resp_i = 1'b1;
            step();
            resp_i = 1'b0;
        end
        mem[la] = data;
        check("wr_write_o_drop", write_o, 1'b0);
        check("wr_read_o_end", read_o, 1'b0);
`ifdef L2_ADAPTOR_WB_BUF_EN
        check("wr_drain_no_resp", resp_o, 1'b0);
`else
        check("wr_resp_o", resp_o, 1'b1);
        write_i = 1'b0;
        step();
        check("wr_resp_o_pulse", resp_o, 1'b0);
        check("wr_read_o_idle", read_o, 1'b0);
`endif
    endtask

    initial begin
        rst       = 1'b0;
        address_i = '0;
        read_i    = 1'b0;
        write_i   = 1'b0;
        line_i    = '0;
        burst_i   = '0;
        resp_i    = 1'b0;
        #3;
        check("rst_read_o", read_o, 1'b0);
        check("rst_write_o", write_o, 1'b0);
        check("rst_resp_o", resp_o, 1'b0);
        check("rst_line_o", line_o, '0);
        check("rst_burst_o", burst_o, '0);
        check("rst_address_o", address_o, '0);
        step();
        rst = 1'b1;
        step();

        // Directed fill with known beats, back-to-back.
        mem[27'h91] = {64'hA3, 64'hA2, 64'hA1, 64'hA0};
        do_fill(32'h0000_1234, 1'b0);

        // Directed writeback with gaps.
        do_write(32'h0000_4040, {64'hD3, 64'hD2, 64'hD1, 64'hD0}, 1'b1, 1'b0);

        // Simultaneous read and write: write first, then the fill of the same line.
        do_write(32'h0000_8000, rand_line(), 1'b1, 1'b1);
        do_fill(32'h0000_8000, 1'b0);

        // resp_i noise while idle must do nothing.
        repeat (4) begin
            resp_i  = 1'b1;
            burst_i = {$urandom, $urandom};
            step();
            check("idle_resp_o", resp_o, 1'b0);
            check("idle_read_o", read_o, 1'b0);
            check("idle_write_o", write_o, 1'b0);
        end
        resp_i  = 1'b0;
        burst_i = '0;

        // Reset after two read beats.
        read_i    = 1'b1;
        address_i = 32'h0000_2000;
        step();
        repeat (2) begin
            resp_i  = 1'b1;
            burst_i = {$urandom, $urandom};
            step();
        end
        resp_i = 1'b0;
        check("mid_read_o", read_o, 1'b1);
        #2;
        rst    = 1'b0;
        read_i = 1'b0;
        #1;
        check("async_rst_read_o", read_o, 1'b0);
        check("async_rst_line_o", line_o, '0);
        check("async_rst_address_o", address_o, '0);
        step();
        rst = 1'b1;
        step();
        check("post_rst_read_o", read_o, 1'b0);
        check("post_rst_resp_o", resp_o, 1'b0);
        check("post_rst_line_o", line_o, '0);
        do_fill(32'h0000_2000, 1'b1);

        // Randomised traffic over a few lines so writes are re-read.
        for (int i = 0; i < 10; i++) begin
            logic [31:0] a;
            a = {25'd0, 2'($urandom_range(0, 3)), 5'($urandom)};
            if ($urandom_range(0, 1) == 1) begin
                do_write(a, rand_line(), 1'b1, 1'($urandom_range(0, 1)));
                if (read_i) do_fill(a, 1'b1);
            end else begin
                do_fill(a, 1'b1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
